// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by an OVERSAMPLE x baud clock enable; outputs valid / frame_err pulses.
// Define UART_RX_SYNC_EN to pass rx through a 2-flop synchronizer (adds 2 clk of latency).
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy,
    output logic [1:0] o_state
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_idx, w_idx_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic [7:0]    r_data, w_data_nxt;
    logic          r_valid, w_valid_nxt;
    logic          r_ferr, w_ferr_nxt;
    logic          w_rx_s;

`ifdef UART_RX_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= 2'b11;
        else        r_sync <= {r_sync[0], rx};
    end

    assign w_rx_s = r_sync[1];
`else
    assign w_rx_s = rx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    // Pulses default low every clk, so they last exactly one cycle regardless of clk_en.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        if (clk_en) begin
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        w_state_nxt = START;
                        w_cnt_nxt   = '0;
                    end
                end
                START: begin
                    if (r_cnt == CNT_HALF) begin
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = 3'd0;
                        w_state_nxt = w_rx_s ? IDLE : DATA;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        w_shift_nxt[r_idx] = w_rx_s;
                        w_cnt_nxt          = '0;
                        if (r_idx == 3'd7) w_state_nxt = STOP;
                        else               w_idx_nxt   = r_idx + 3'd1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                STOP: begin
                    // Leave at the stop-bit centre so a start edge right after it is not missed.
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                        if (w_rx_s) begin
                            w_data_nxt  = r_shift;
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_ferr_nxt = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_ferr;
    assign busy      = (r_state != IDLE);
    assign o_state   = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are described per bit, and the expected
// valid/frame_err events (kind, data, tick) are derived from the frame timing rules.
module tb_uart_rx;

    localparam int OS = 16;
    localparam int EW = 41;   // {kind(1=valid,0=frame_err), data[7:0], tick[31:0]}
`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       clk_en;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;
    logic [1:0] o_state;

    int unsigned   n_vec;
    int unsigned   n_fail;
    int unsigned   overlap_n;
    logic [31:0]   tick_n;
    logic [7:0]    model_data;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs_q[$];

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy),
        .o_state   (o_state)
    );

    // ---------------- clock / tick counter / monitor ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial tick_n = 32'd0;
    always @(posedge clk) if (clk_en) tick_n <= tick_n + 32'd1;

    initial overlap_n = 0;
    always @(negedge clk) begin
        if (valid)              obs_q.push_back({1'b1, data, tick_n});
        if (frame_err)          obs_q.push_back({1'b0, data, tick_n});
        if (valid && frame_err) overlap_n++;
    end

    // ---------------- reference model ----------------
    // The stop bit is sampled 152 ticks (start half-bit + 8 data bits + stop bit) after
    // the first tick that sees the line low; the synchronizer delays that by LAT.
    task automatic model_frame(input logic [7:0] b, input logic stop_bit, input logic [31:0] t0);
        logic [31:0] t;
        t = t0 + 32'd152 + 32'(LAT);
        if (stop_bit) begin
            exp_q.push_back({1'b1, b, t});
            model_data = b;
        end else begin
            exp_q.push_back({1'b0, model_data, t});
        end
    endtask

    // ---------------- drivers ----------------
    task automatic idle_ticks(input int n);
        rx     = 1'b1;
        clk_en = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f      = {stop_bit, b, 1'b0};
        clk_en = 1'b1;
        model_frame(b, stop_bit, tick_n + 32'd1);
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < OS; j++) begin
                rx = f[i];
                @(negedge clk);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rx = 1'b1; clk_en = 1'b1; rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({data, valid, frame_err, busy} !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_async: data=%h valid=%b ferr=%b busy=%b, required 00/0/0/0", data, valid, frame_err, busy);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if ({data, valid, frame_err, busy} !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_hold: data=%h valid=%b ferr=%b busy=%b, required 00/0/0/0", data, valid, frame_err, busy);
        end
        rst_n = 1'b1;
        model_data = 8'h00;
        idle_ticks(5);
        n_vec++;
        if (busy !== 1'b0 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b events=%0d, required 0/0", busy, obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_single_frame();
        logic [EW-1:0] e, o;
        send_frame(8'h55, 1'b1);
        idle_ticks(4);
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL single_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL single_event: got kind=%b data=%h tick=%0d, required kind=%b data=%h tick=%0d",
                         o[40], o[39:32], o[31:0], e[40], e[39:32], e[31:0]);
            end
        end
        n_vec++;
        if (busy !== 1'b0 || data !== 8'h55) begin
            n_fail++;
            $display("FAIL single_after: busy=%b data=%h, required 0/55", busy, data);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_false_start();
        logic [31:0] t0;
        clk_en = 1'b1;
        t0 = tick_n + 32'd1;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        while (tick_n != t0 + 32'd7 + 32'(LAT)) @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL false_start_busy_hi: busy=%b at tick %0d, required 1", busy, tick_n - t0);
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL false_start_busy_lo: busy=%b at tick %0d, required 0", busy, tick_n - t0);
        end
        idle_ticks(20);
        n_vec++;
        if (obs_q.size() != 0 || data !== model_data) begin
            n_fail++;
            $display("FAIL false_start_events: events=%0d data=%h, required 0/%h", obs_q.size(), data, model_data);
        end
        obs_q.delete();
    endtask

    task automatic test_frame_err();
        logic [EW-1:0] e, o;
        send_frame(8'h55, 1'b1);
        send_frame(8'hA3, 1'b0);
        idle_ticks(30);
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL ferr_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL ferr_event: got kind=%b data=%h tick=%0d, required kind=%b data=%h tick=%0d",
                         o[40], o[39:32], o[31:0], e[40], e[39:32], e[31:0]);
            end
        end
        n_vec++;
        if (data !== 8'h55 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ferr_data: data=%h busy=%b, required 55/0", data, busy);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [EW-1:0] e, o;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle_ticks(4);
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b_event: got kind=%b data=%h tick=%0d, required kind=%b data=%h tick=%0d",
                         o[40], o[39:32], o[31:0], e[40], e[39:32], e[31:0]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_mid_reset();
        logic [EW-1:0] e, o;
        logic [9:0]    f;
        f = {1'b1, 8'hC9, 1'b0};
        clk_en = 1'b1;
        for (int i = 0; i <= 88; i++) begin   // up to the middle of data bit 4
            rx = f[i / OS];
            @(negedge clk);
        end
        n_vec++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre: busy=%b, required 1", busy);
        end
        #2 rst_n = 1'b0;
        rx = 1'b1;
        #1;
        n_vec++;
        if (busy !== 1'b0 || valid !== 1'b0 || frame_err !== 1'b0 || data !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_async: busy=%b valid=%b ferr=%b data=%h, required 0/0/0/00", busy, valid, frame_err, data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_data = 8'h00;
        idle_ticks(20);
        send_frame(8'h3C, 1'b1);
        idle_ticks(4);
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL midrst_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL midrst_event: got kind=%b data=%h tick=%0d, required kind=%b data=%h tick=%0d",
                         o[40], o[39:32], o[31:0], e[40], e[39:32], e[31:0]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_clk_en_hold();
        logic [EW-1:0] e, o;
        logic [9:0]    f;
        logic [1:0]    st;
        logic [7:0]    dt;
        f = {1'b1, 8'h96, 1'b0};
        clk_en = 1'b1;
        model_frame(8'h96, 1'b1, tick_n + 32'd1);
        for (int i = 0; i < 10 * OS; i++) begin
            if (i == 45) begin   // pause inside data bit 1
                st = o_state;
                dt = data;
                clk_en = 1'b0;
                for (int k = 0; k < 200; k++) begin
                    rx = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    n_vec++;
                    if (o_state !== st || busy !== 1'b1 || data !== dt || valid !== 1'b0 || frame_err !== 1'b0) begin
                        n_fail++;
                        $display("FAIL hold_cycle%0d: state=%0d busy=%b data=%h valid=%b ferr=%b, required state=%0d busy=1 data=%h valid=0 ferr=0",
                                 k, o_state, busy, data, valid, frame_err, st, dt);
                    end
                end
                rx = f[i / OS];
                repeat (3) @(negedge clk);
                clk_en = 1'b1;
            end
            rx = f[i / OS];
            @(negedge clk);
        end
        idle_ticks(4);
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL hold_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL hold_event: got kind=%b data=%h tick=%0d, required kind=%b data=%h tick=%0d",
                         o[40], o[39:32], o[31:0], e[40], e[39:32], e[31:0]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_random();
        logic [EW-1:0] e, o;
        logic [7:0]    b;
        logic          sb;
        for (int n = 0; n < 14; n++) begin
            b  = 8'($urandom_range(0, 255));
            sb = ($urandom_range(0, 3) != 0);
            send_frame(b, sb);
            if (!sb) idle_ticks(24);
            else     idle_ticks($urandom_range(0, 12));
        end
        idle_ticks(4);
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rand_event: got kind=%b data=%h tick=%0d, required kind=%b data=%h tick=%0d",
                         o[40], o[39:32], o[31:0], e[40], e[39:32], e[31:0]);
            end
        end
        n_vec++;
        if (data !== model_data || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_hold: data=%h busy=%b, required %h/0", data, busy, model_data);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_vec = 0; n_fail = 0;
        model_data = 8'h00;
        rx = 1'b1; clk_en = 1'b1; rst_n = 1'b1;
        test_reset();
        test_single_frame();
        test_false_start();
        test_frame_err();
        test_back_to_back();
        test_mid_reset();
        test_clk_en_hold();
        test_random();
        n_vec++;
        if (overlap_n != 0) begin
            n_fail++;
            $display("FAIL pulse_overlap: %0d cycles with valid and frame_err together, required 0", overlap_n);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
